// File: rtl/fp_utils_pkg.sv
// Shared floating-point helpers: sample class enum and field-index helpers.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package fp_utils_pkg;

  // Sample classes produced by floating_point_classifier
  typedef enum logic [1:0] {
    FP_ZERO    = 2'd0,
    FP_SUB     = 2'd1,
    FP_NORMAL  = 2'd2,
    FP_SPECIAL = 2'd3
  } fp_class_e;

  // Sample layout is {sign, exp, frac}; fraction always starts at bit 0
  localparam int FP_FRAC_LSB = 0;

  function automatic int fp_frac_msb(input int frac_width);
    return frac_width - 1;
  endfunction

  function automatic int fp_exp_lsb(input int frac_width);
    return frac_width;
  endfunction

  function automatic int fp_exp_msb(input int exp_width, input int frac_width);
    return frac_width + exp_width - 1;
  endfunction

  function automatic int fp_sign_bit(input int exp_width, input int frac_width);
    return frac_width + exp_width;
  endfunction

endpackage

// File: rtl/floating_point_classifier.sv
// Classifies a sample's exp/frac fields as zero, subnormal, normal or Inf/NaN.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module floating_point_classifier
  import fp_utils_pkg::*;
#(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 23
) (
  input  logic [EXP_WIDTH-1:0]  exp_i,
  input  logic [FRAC_WIDTH-1:0] frac_i,
  output fp_class_e             class_o
);

  localparam logic [EXP_WIDTH-1:0] EXP_ALL_ONES = '1;

  // Sign is irrelevant to the class; only exponent and fraction matter
  always_comb begin
    class_o = FP_NORMAL;
    if (exp_i == '0) begin
      class_o = (frac_i == '0) ? FP_ZERO : FP_SUB;
    end else if (exp_i == EXP_ALL_ONES) begin
      class_o = FP_SPECIAL;
    end
  end

endmodule

// File: rtl/floating_point_frame_exponent_tracker.sv
// Forwards samples unchanged and reports per-frame max exponent and class counts.
// Latency: 1 cycle for fp_o/valid_o; frame_valid_o coincides with valid_o of the closing sample.
// Backpressure: none; every valid sample is accepted.
module floating_point_frame_exponent_tracker
  import fp_utils_pkg::*;
#(
  parameter  int EXP_WIDTH    = 0,
  parameter  int FRAC_WIDTH   = 0,
  parameter  int FRAME_LEN    = 16,
  localparam int FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH,
  localparam int EXP_MAX      = 2**EXP_WIDTH - 1,
  localparam int CNT_WIDTH    = $clog2(FRAME_LEN + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [FP_WIDTH_REG-1:0] fp_i,
  input  logic                    valid_i,
  input  logic                    flush_i,
  output logic [FP_WIDTH_REG-1:0] fp_o,
  output logic                    valid_o,
  output logic                    frame_valid_o,
  output logic [EXP_WIDTH-1:0]    frame_max_exp_o,
  output logic [CNT_WIDTH-1:0]    frame_zero_cnt_o,
  output logic [CNT_WIDTH-1:0]    frame_sub_cnt_o,
  output logic [CNT_WIDTH-1:0]    frame_special_cnt_o,
  output logic [CNT_WIDTH-1:0]    frame_len_o
);

  localparam int EXP_LSB  = fp_exp_lsb(FRAC_WIDTH);
  localparam int EXP_MSB  = fp_exp_msb(EXP_WIDTH, FRAC_WIDTH);
  localparam int FRAC_MSB = fp_frac_msb(FRAC_WIDTH);
  localparam logic [CNT_WIDTH-1:0] FRAME_LEN_C = CNT_WIDTH'(FRAME_LEN);

  logic [EXP_WIDTH-1:0]  exp_w;
  logic [FRAC_WIDTH-1:0] frac_w;
  fp_class_e             cls_w;

  assign exp_w  = fp_i[EXP_MSB:EXP_LSB];
  assign frac_w = fp_i[FRAC_MSB:FP_FRAC_LSB];

  floating_point_classifier #(
    .EXP_WIDTH  (EXP_WIDTH),
    .FRAC_WIDTH (FRAC_WIDTH)
  ) u_classifier (
    .exp_i   (exp_w),
    .frac_i  (frac_w),
    .class_o (cls_w)
  );

  logic is_zero, is_sub, is_normal, is_special;
  assign is_zero    = valid_i && (cls_w == FP_ZERO);
  assign is_sub     = valid_i && (cls_w == FP_SUB);
  assign is_normal  = valid_i && (cls_w == FP_NORMAL);
  assign is_special = valid_i && (cls_w == FP_SPECIAL);

  // Running frame state; a frame is open whenever cnt_q is non-zero
  logic [CNT_WIDTH-1:0] cnt_q, zero_q, sub_q, spec_q;
  logic [EXP_WIDTH-1:0] max_q;
  logic                 seen_q;

  logic [CNT_WIDTH-1:0] cnt_d, zero_d, sub_d, spec_d;
  logic [EXP_WIDTH-1:0] max_d;
  logic                 seen_d;
  logic                 close_w;

  // Statistics including the current sample, used both to advance and to close
  always_comb begin
    cnt_d  = cnt_q  + {{(CNT_WIDTH-1){1'b0}}, valid_i};
    zero_d = zero_q + {{(CNT_WIDTH-1){1'b0}}, is_zero};
    sub_d  = sub_q  + {{(CNT_WIDTH-1){1'b0}}, is_sub};
    spec_d = spec_q + {{(CNT_WIDTH-1){1'b0}}, is_special};
    seen_d = seen_q | is_normal;
    max_d  = max_q;
    if (is_normal && (!seen_q || (exp_w > max_q))) begin
      max_d = exp_w;
    end
  end

  // A flush on an empty frame with no sample this cycle leaves cnt_d at zero and is ignored
  assign close_w = (valid_i && (cnt_d == FRAME_LEN_C)) || (flush_i && (cnt_d != '0));

  // One-stage pass-through register, independent of frame logic
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fp_o    <= '0;
      valid_o <= 1'b0;
    end else begin
      fp_o    <= fp_i;
      valid_o <= valid_i;
    end
  end

  // Advance running state, clearing it on the edge that closes the frame
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      zero_q <= '0;
      sub_q  <= '0;
      spec_q <= '0;
      max_q  <= '0;
      seen_q <= 1'b0;
    end else if (close_w) begin
      cnt_q  <= '0;
      zero_q <= '0;
      sub_q  <= '0;
      spec_q <= '0;
      max_q  <= '0;
      seen_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      zero_q <= zero_d;
      sub_q  <= sub_d;
      spec_q <= spec_d;
      max_q  <= max_d;
      seen_q <= seen_d;
    end
  end

  // Publish frame statistics on close and hold them until the next close
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frame_valid_o       <= 1'b0;
      frame_max_exp_o     <= '0;
      frame_zero_cnt_o    <= '0;
      frame_sub_cnt_o     <= '0;
      frame_special_cnt_o <= '0;
      frame_len_o         <= '0;
    end else begin
      frame_valid_o <= close_w;
      if (close_w) begin
        frame_max_exp_o     <= seen_d ? max_d : '0;
        frame_zero_cnt_o    <= zero_d;
        frame_sub_cnt_o     <= sub_d;
        frame_special_cnt_o <= spec_d;
        frame_len_o         <= cnt_d;
      end
    end
  end

endmodule

// File: tb/tb_floating_point_frame_exponent_tracker.sv
// Directed bench for floating_point_frame_exponent_tracker (binary32 layout, 4-sample frames).
// Latency: checks outputs 1 time unit after each rising edge.
// Backpressure: none exercised; the design accepts every sample.
module tb_floating_point_frame_exponent_tracker;

  localparam int EW = 8;
  localparam int FW = 23;
  localparam int FL = 4;
  localparam int CW = $clog2(FL + 1);

  logic          clk;
  logic          rst_n;
  logic [31:0]   fp_in;
  logic          vld_in;
  logic          flush_in;
  logic [31:0]   fp_out;
  logic          vld_out;
  logic          frame_vld;
  logic [EW-1:0] max_exp;
  logic [CW-1:0] zero_cnt, sub_cnt, spec_cnt, len_cnt;

  int n_cmp = 0;
  int n_err = 0;

  floating_point_frame_exponent_tracker #(
    .EXP_WIDTH  (EW),
    .FRAC_WIDTH (FW),
    .FRAME_LEN  (FL)
  ) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .fp_i                (fp_in),
    .valid_i             (vld_in),
    .flush_i             (flush_in),
    .fp_o                (fp_out),
    .valid_o             (vld_out),
    .frame_valid_o       (frame_vld),
    .frame_max_exp_o     (max_exp),
    .frame_zero_cnt_o    (zero_cnt),
    .frame_sub_cnt_o     (sub_cnt),
    .frame_special_cnt_o (spec_cnt),
    .frame_len_o         (len_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Apply one cycle of inputs, then land just after the capturing edge
  task automatic step(input logic v, input logic [31:0] d, input logic fl);
    @(negedge clk);
    vld_in   = v;
    fp_in    = d;
    flush_in = fl;
    @(posedge clk);
    #1;
  endtask

  // Sample step with pass-through and pulse checks
  task automatic samp(input string tag, input logic [31:0] d, input logic fl, input logic pulse);
    step(1'b1, d, fl);
    chk({tag, ".fp_o"}, fp_out, d);
    chk({tag, ".valid_o"}, {31'd0, vld_out}, 32'd1);
    chk({tag, ".frame_valid"}, {31'd0, frame_vld}, {31'd0, pulse});
  endtask

  task automatic chk_frame(input string tag, input int mx, input int z, input int s,
                           input int sp, input int ln);
    chk({tag, ".max_exp"}, {24'd0, max_exp}, mx);
    chk({tag, ".zero"}, {29'd0, zero_cnt}, z);
    chk({tag, ".sub"}, {29'd0, sub_cnt}, s);
    chk({tag, ".special"}, {29'd0, spec_cnt}, sp);
    chk({tag, ".len"}, {29'd0, len_cnt}, ln);
  endtask

  function automatic logic [31:0] mk(input logic [7:0] e);
    return {1'b0, e, 23'h0};
  endfunction

  initial begin
    rst_n    = 1'b0;
    vld_in   = 1'b0;
    fp_in    = '0;
    flush_in = 1'b0;
    #1;
    // Reset state
    chk("rst.fp_o", fp_out, 32'h0);
    chk("rst.valid_o", {31'd0, vld_out}, 32'd0);
    chk("rst.frame_valid", {31'd0, frame_vld}, 32'd0);
    chk_frame("rst", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Mixed frame: 1.0 (exp 7F), 2.0 (exp 80), zero, smallest subnormal
    samp("t1.s0", 32'h3F800000, 1'b0, 1'b0);
    samp("t1.s1", 32'h40000000, 1'b0, 1'b0);
    samp("t1.s2", 32'h00000000, 1'b0, 1'b0);
    samp("t1.s3", 32'h00000001, 1'b0, 1'b1);
    chk_frame("t1", 8'h80, 1, 1, 0, 4);
    step(1'b0, 32'h0, 1'b0);
    chk("t1.idle.valid_o", {31'd0, vld_out}, 32'd0);
    chk("t1.idle.frame_valid", {31'd0, frame_vld}, 32'd0);
    chk_frame("t1.hold", 8'h80, 1, 1, 0, 4);

    // No normal samples: +Inf, -NaN, +0, -0
    samp("t2.s0", 32'h7F800000, 1'b0, 1'b0);
    samp("t2.s1", 32'hFFC00000, 1'b0, 1'b0);
    samp("t2.s2", 32'h00000000, 1'b0, 1'b0);
    samp("t2.s3", 32'h80000000, 1'b0, 1'b1);
    chk_frame("t2", 0, 2, 0, 2, 4);

    // Flush together with the third sample, then a full independent frame
    samp("t3.s0", 32'h40400000, 1'b0, 1'b0);
    samp("t3.s1", 32'h3F000000, 1'b0, 1'b0);
    samp("t3.s2", 32'h00000002, 1'b1, 1'b1);
    chk_frame("t3a", 8'h80, 0, 1, 0, 3);
    samp("t3.s3", 32'h41000000, 1'b0, 1'b0);
    samp("t3.s4", 32'h7F800000, 1'b0, 1'b0);
    samp("t3.s5", 32'h00000000, 1'b0, 1'b0);
    samp("t3.s6", 32'h3E800000, 1'b0, 1'b1);
    chk_frame("t3b", 8'h82, 1, 0, 1, 4);

    // Flush with no open frame and no sample: ignored
    step(1'b0, 32'h0, 1'b1);
    chk("t4.frame_valid", {31'd0, frame_vld}, 32'd0);
    chk_frame("t4.hold", 8'h82, 1, 0, 1, 4);

    // Flush alone closes a one-sample frame; then back-to-back single-sample flushes
    samp("t5.s0", 32'h3F800000, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    chk("t5.flush.frame_valid", {31'd0, frame_vld}, 32'd1);
    chk_frame("t5a", 8'h7F, 0, 0, 0, 1);
    samp("t5.s1", 32'h40000000, 1'b1, 1'b1);
    chk_frame("t5b", 8'h80, 0, 0, 0, 1);
    samp("t5.s2", 32'h00000000, 1'b1, 1'b1);
    chk_frame("t5c", 0, 1, 0, 0, 1);

    // Asynchronous reset mid-frame discards the partial frame
    samp("t6.s0", 32'h3F800000, 1'b0, 1'b0);
    samp("t6.s1", 32'h40800000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6.rst.fp_o", fp_out, 32'h0);
    chk("t6.rst.valid_o", {31'd0, vld_out}, 32'd0);
    chk("t6.rst.frame_valid", {31'd0, frame_vld}, 32'd0);
    chk_frame("t6.rst", 0, 0, 0, 0, 0);
    vld_in   = 1'b0;
    flush_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    samp("t6.s2", 32'h00000001, 1'b0, 1'b0);
    samp("t6.s3", 32'h00000001, 1'b0, 1'b0);
    samp("t6.s4", 32'h3F800000, 1'b0, 1'b0);
    samp("t6.s5", 32'h7FC00000, 1'b0, 1'b1);
    chk_frame("t6", 8'h7F, 0, 2, 1, 4);

    // Twelve back-to-back samples: three frames, pulses 4 cycles apart
    samp("t7.a0", mk(8'h10), 1'b0, 1'b0);
    samp("t7.a1", mk(8'h20), 1'b0, 1'b0);
    samp("t7.a2", mk(8'h30), 1'b0, 1'b0);
    samp("t7.a3", mk(8'h05), 1'b0, 1'b1);
    chk_frame("t7a", 8'h30, 0, 0, 0, 4);
    samp("t7.b0", mk(8'h7F), 1'b0, 1'b0);
    samp("t7.b1", mk(8'h01), 1'b0, 1'b0);
    samp("t7.b2", 32'h80000000 | mk(8'hFE), 1'b0, 1'b0);
    samp("t7.b3", mk(8'h80), 1'b0, 1'b1);
    chk_frame("t7b", 8'hFE, 0, 0, 0, 4);
    samp("t7.c0", 32'h00400000, 1'b0, 1'b0);
    samp("t7.c1", mk(8'h44), 1'b0, 1'b0);
    samp("t7.c2", 32'h00000000, 1'b0, 1'b0);
    samp("t7.c3", mk(8'h43), 1'b0, 1'b1);
    chk_frame("t7c", 8'h44, 1, 1, 0, 4);
    step(1'b0, 32'h0, 1'b0);
    chk("t7.tail.frame_valid", {31'd0, frame_vld}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
